mem_wb_stage: RTL and testbench

Memory-access stage of the five-stage pipeline plus the MEM/WB pipeline register. It consumes the registered outputs of the EX/MEM register and runs loads and stores against the data memory over a req/ack handshake. While an access is outstanding it stalls the upstream stages. It presents MEM/WB values (ALU result, load data, destination register, write-back controls) to the write-back stage.

---
 rtl/pipe_pkg.sv | 14 +
 rtl/mem_wb_reg.sv | 43 ++++
 rtl/mem_wb_stage.sv | 105 ++++++++++
 tb/tb_mem_wb_stage.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared types and constants for the MEM/WB pipeline slice
package pipe_pkg;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_RD_W   = 5;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_state_t;

  // A bubble never writes the register file and never selects load data.
  localparam logic BUBBLE_REG_WRITE  = 1'b0;
  localparam logic BUBBLE_MEM_TO_REG = 1'b0;
endpackage

// File: rtl/mem_wb_reg.sv
// rtl/mem_wb_reg.sv - MEM/WB pipeline register with bubble insertion
module mem_wb_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int RD_W   = DEF_RD_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              bubble,
  input  logic [DATA_W-1:0] alu_next,
  input  logic [DATA_W-1:0] mem_data_next,
  input  logic [RD_W-1:0]   rd_next,
  input  logic              reg_write_next,
  input  logic              mem_to_reg_next,
  output logic [DATA_W-1:0] ALUout_o,
  output logic [DATA_W-1:0] MemData_o,
  output logic [RD_W-1:0]   RegistersRD_o,
  output logic              RegWrite_o,
  output logic              MemtoReg_o
);
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ALUout_o      <= '0;
      MemData_o     <= '0;
      RegistersRD_o <= '0;
      RegWrite_o    <= BUBBLE_REG_WRITE;
      MemtoReg_o    <= BUBBLE_MEM_TO_REG;
    end else if (bubble) begin
      ALUout_o      <= '0;
      MemData_o     <= '0;
      RegistersRD_o <= '0;
      RegWrite_o    <= BUBBLE_REG_WRITE;
      MemtoReg_o    <= BUBBLE_MEM_TO_REG;
    end else begin
      ALUout_o      <= alu_next;
      MemData_o     <= mem_data_next;
      RegistersRD_o <= rd_next;
      RegWrite_o    <= reg_write_next;
      MemtoReg_o    <= mem_to_reg_next;
    end
  end
endmodule

// File: rtl/mem_wb_stage.sv
// rtl/mem_wb_stage.sv - memory-access stage: data memory handshake, stall and MEM/WB register
module mem_wb_stage
  import pipe_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int RD_W   = DEF_RD_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [DATA_W-1:0] ALUout_i,
  input  logic [DATA_W-1:0] regB_i,
  input  logic [RD_W-1:0]   RegistersRD_i,
  input  logic              RegWrite_i,
  input  logic              MemtoReg_i,
  input  logic              MemWrite_i,
  input  logic              MemRead_i,
  output logic              dmem_req_o,
  output logic              dmem_we_o,
  output logic [DATA_W-1:0] dmem_addr_o,
  output logic [DATA_W-1:0] dmem_wdata_o,
  input  logic              dmem_ack_i,
  input  logic [DATA_W-1:0] dmem_rdata_i,
  output logic              stall_o,
  output logic [DATA_W-1:0] ALUout_o,
  output logic [DATA_W-1:0] MemData_o,
  output logic [RD_W-1:0]   RegistersRD_o,
  output logic              RegWrite_o,
  output logic              MemtoReg_o
);
  mem_state_t        state_q, state_d;
  logic              req_q, we_q;
  logic [DATA_W-1:0] addr_q, wdata_q;
  logic              mem_op, ack, start;
  logic [DATA_W-1:0] mem_data_next;

  assign mem_op = MemRead_i | MemWrite_i;
  assign ack    = (state_q == WAIT) && dmem_ack_i;
  assign start  = (state_q == IDLE) && mem_op;

  always_comb begin
    state_d = state_q;
    stall_o = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_op) begin
          stall_o = 1'b1;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (ack) state_d = IDLE;
        else     stall_o = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (start) begin
        // A combined read/write request is treated as a write.
        req_q   <= 1'b1;
        we_q    <= MemWrite_i;
        addr_q  <= {ALUout_i[DATA_W-1:2], 2'b00};
        wdata_q <= regB_i;
      end else if (ack) begin
        req_q <= 1'b0;
      end
    end
  end

  assign dmem_req_o   = req_q;
  assign dmem_we_o    = we_q;
  assign dmem_addr_o  = addr_q;
  assign dmem_wdata_o = wdata_q;

  // Only the ack cycle of a read commits; that is the only unstalled WAIT cycle.
  assign mem_data_next = ((state_q == WAIT) && !we_q) ? dmem_rdata_i : '0;

  mem_wb_reg #(
    .DATA_W(DATA_W),
    .RD_W  (RD_W)
  ) u_mem_wb_reg (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .bubble         (stall_o),
    .alu_next       (ALUout_i),
    .mem_data_next  (mem_data_next),
    .rd_next        (RegistersRD_i),
    .reg_write_next (RegWrite_i),
    .mem_to_reg_next(MemtoReg_i),
    .ALUout_o       (ALUout_o),
    .MemData_o      (MemData_o),
    .RegistersRD_o  (RegistersRD_o),
    .RegWrite_o     (RegWrite_o),
    .MemtoReg_o     (MemtoReg_o)
  );
endmodule

// File: tb/tb_mem_wb_stage.sv
// tb/tb_mem_wb_stage.sv - directed self-checking bench for mem_wb_stage
module tb_mem_wb_stage;
  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] ALUout_i, regB_i, dmem_rdata_i;
  logic [4:0]  RegistersRD_i;
  logic        RegWrite_i, MemtoReg_i, MemWrite_i, MemRead_i, dmem_ack_i;
  logic        dmem_req_o, dmem_we_o, stall_o, RegWrite_o, MemtoReg_o;
  logic [31:0] dmem_addr_o, dmem_wdata_o, ALUout_o, MemData_o;
  logic [4:0]  RegistersRD_o;

  int tests  = 0;
  int failed = 0;
  int stalls;

  bit mon = 1'b0;
  bit prev_req, counting;
  int wb_cnt, rises, gap, last_gap;

  always #5 clk_i = ~clk_i;

  mem_wb_stage dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .ALUout_i(ALUout_i), .regB_i(regB_i), .RegistersRD_i(RegistersRD_i),
    .RegWrite_i(RegWrite_i), .MemtoReg_i(MemtoReg_i),
    .MemWrite_i(MemWrite_i), .MemRead_i(MemRead_i),
    .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o),
    .dmem_addr_o(dmem_addr_o), .dmem_wdata_o(dmem_wdata_o),
    .dmem_ack_i(dmem_ack_i), .dmem_rdata_i(dmem_rdata_i),
    .stall_o(stall_o), .ALUout_o(ALUout_o), .MemData_o(MemData_o),
    .RegistersRD_o(RegistersRD_o), .RegWrite_o(RegWrite_o), .MemtoReg_o(MemtoReg_o)
  );

  // Back-to-back observer: write-back count, request rises, idle gap between requests.
  always @(negedge clk_i) begin
    if (mon) begin
      if (RegWrite_o && MemtoReg_o) wb_cnt++;
      if (dmem_req_o && !prev_req) rises++;
      if (!dmem_req_o) begin
        if (prev_req) begin counting = 1'b1; gap = 0; end
        if (counting) gap++;
      end else if (counting) begin
        last_gap = gap;
        counting = 1'b0;
      end
      prev_req = dmem_req_o;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_in(input logic [31:0] alu, input logic [31:0] b, input logic [4:0] rd,
                        input logic rw, input logic m2r, input logic mw, input logic mr);
    ALUout_i = alu; regB_i = b; RegistersRD_i = rd;
    RegWrite_i = rw; MemtoReg_i = m2r; MemWrite_i = mw; MemRead_i = mr;
  endtask

  // Entered just after an edge with a memory instruction on the inputs; returns just
  // after the ack edge with the inputs changed to a nop.
  task automatic run_mem(input string tag, input int nowait, input logic [31:0] rdata,
                         input logic [31:0] exp_addr, input logic exp_we,
                         input logic [31:0] exp_wdata, output int n_stall);
    n_stall = 0;
    for (int c = 0; c <= nowait; c++) begin
      #1;
      if (stall_o) n_stall++;
      tick();
    end
    dmem_ack_i   = 1'b1;
    dmem_rdata_i = rdata;
    #1;
    if (stall_o) n_stall++;
    chk({tag, "_req"},    {31'd0, dmem_req_o}, 32'd1);
    chk({tag, "_addr"},   dmem_addr_o, exp_addr);
    chk({tag, "_we"},     {31'd0, dmem_we_o}, {31'd0, exp_we});
    chk({tag, "_wdata"},  dmem_wdata_o, exp_wdata);
    chk({tag, "_bubble"}, {31'd0, RegWrite_o}, 32'd0);
    tick();
    dmem_ack_i   = 1'b0;
    dmem_rdata_i = 32'h0;
    set_in(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst_i = 1'b0;
    dmem_ack_i = 1'b0;
    dmem_rdata_i = 32'h0;
    set_in(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    chk("rst_req",   {31'd0, dmem_req_o}, 32'd0);
    chk("rst_we",    {31'd0, dmem_we_o}, 32'd0);
    chk("rst_addr",  dmem_addr_o, 32'd0);
    chk("rst_wdata", dmem_wdata_o, 32'd0);
    chk("rst_stall", {31'd0, stall_o}, 32'd0);
    chk("rst_alu",   ALUout_o, 32'd0);
    chk("rst_mdata", MemData_o, 32'd0);
    chk("rst_rd",    {27'd0, RegistersRD_o}, 32'd0);
    chk("rst_rw",    {31'd0, RegWrite_o}, 32'd0);
    rst_i = 1'b1;
    tick();

    // ALU instruction passes straight through in one edge.
    set_in(32'h10, 32'h0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    #1 chk("alu_stall", {31'd0, stall_o}, 32'd0);
    tick();
    set_in(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("alu_rw",  {31'd0, RegWrite_o}, 32'd1);
    chk("alu_rd",  {27'd0, RegistersRD_o}, 32'd5);
    chk("alu_out", ALUout_o, 32'h10);
    chk("alu_stall_after", {31'd0, stall_o}, 32'd0);

    // Load with three ack-less WAIT cycles.
    set_in(32'h107, 32'h0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b1);
    run_mem("ld", 3, 32'hDEADBEEF, 32'h104, 1'b0, 32'h0, stalls);
    chk("ld_stalls", stalls, 32'd4);
    chk("ld_mdata",  MemData_o, 32'hDEADBEEF);
    chk("ld_m2r",    {31'd0, MemtoReg_o}, 32'd1);
    chk("ld_rw",     {31'd0, RegWrite_o}, 32'd1);
    chk("ld_rd",     {27'd0, RegistersRD_o}, 32'd7);
    chk("ld_alu",    ALUout_o, 32'h107);
    chk("ld_req_drop", {31'd0, dmem_req_o}, 32'd0);
    tick();
    chk("ld_after_nop", {31'd0, MemtoReg_o}, 32'd0);

    // Store with immediate ack.
    set_in(32'h20, 32'h55, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    run_mem("st", 0, 32'hCAFEF00D, 32'h20, 1'b1, 32'h55, stalls);
    chk("st_stalls", stalls, 32'd1);
    chk("st_rw",     {31'd0, RegWrite_o}, 32'd0);
    chk("st_mdata",  MemData_o, 32'd0);
    chk("st_alu",    ALUout_o, 32'h20);

    // Read and write together: write wins, no load data.
    set_in(32'h42, 32'h99, 5'd9, 1'b1, 1'b1, 1'b1, 1'b1);
    run_mem("rw", 1, 32'h12345678, 32'h40, 1'b1, 32'h99, stalls);
    chk("rw_stalls", stalls, 32'd2);
    chk("rw_mdata",  MemData_o, 32'd0);
    chk("rw_rd",     {27'd0, RegistersRD_o}, 32'd9);

    // Spurious ack in IDLE is ignored.
    set_in(32'h8, 32'h0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    dmem_ack_i = 1'b1;
    dmem_rdata_i = 32'hFFFF_FFFF;
    #1 chk("sp_stall", {31'd0, stall_o}, 32'd0);
    tick();
    dmem_ack_i = 1'b0;
    set_in(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("sp_req",   {31'd0, dmem_req_o}, 32'd0);
    chk("sp_mdata", MemData_o, 32'd0);
    chk("sp_rd",    {27'd0, RegistersRD_o}, 32'd3);
    tick();

    // Reset asserted in WAIT aborts the access.
    set_in(32'h80, 32'h0, 5'd4, 1'b1, 1'b1, 1'b0, 1'b1);
    tick();
    chk("rw_wait_req", {31'd0, dmem_req_o}, 32'd1);
    rst_i = 1'b0;
    #1;
    chk("ra_req",   {31'd0, dmem_req_o}, 32'd0);
    chk("ra_addr",  dmem_addr_o, 32'd0);
    chk("ra_rd",    {27'd0, RegistersRD_o}, 32'd0);
    chk("ra_rw",    {31'd0, RegWrite_o}, 32'd0);
    set_in(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1 chk("ra_idle_stall", {31'd0, stall_o}, 32'd0);
    tick();
    rst_i = 1'b1;
    dmem_ack_i = 1'b1;
    #1 chk("ra_no_wait", {31'd0, stall_o}, 32'd0);
    tick();
    dmem_ack_i = 1'b0;
    chk("ra_no_wb_rw", {31'd0, RegWrite_o}, 32'd0);
    chk("ra_no_wb_md", MemData_o, 32'd0);

    // Two back-to-back loads, each acked in its first WAIT cycle.
    prev_req = 1'b0; counting = 1'b0;
    wb_cnt = 0; rises = 0; gap = 0; last_gap = -1;
    mon = 1'b1;
    set_in(32'h100, 32'h0, 5'd1, 1'b1, 1'b1, 1'b0, 1'b1);
    #1 chk("bb_a_stall", {31'd0, stall_o}, 32'd1);
    tick();
    dmem_ack_i = 1'b1;
    dmem_rdata_i = 32'hA;
    #1 chk("bb_a_ack_stall", {31'd0, stall_o}, 32'd0);
    tick();
    dmem_ack_i = 1'b0;
    set_in(32'h200, 32'h0, 5'd2, 1'b1, 1'b1, 1'b0, 1'b1);
    chk("bb_gap_req", {31'd0, dmem_req_o}, 32'd0);
    chk("bb_a_rd",    {27'd0, RegistersRD_o}, 32'd1);
    chk("bb_a_data",  MemData_o, 32'hA);
    tick();
    dmem_ack_i = 1'b1;
    dmem_rdata_i = 32'hB;
    chk("bb_b_addr", dmem_addr_o, 32'h200);
    tick();
    dmem_ack_i = 1'b0;
    set_in(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("bb_b_rd",   {27'd0, RegistersRD_o}, 32'd2);
    chk("bb_b_data", MemData_o, 32'hB);
    tick();
    tick();
    mon = 1'b0;
    chk("bb_wb_cnt", wb_cnt, 32'd2);
    chk("bb_rises",  rises, 32'd2);
    chk("bb_gap",    last_gap, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
